// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one aligned word read at pc over a
// valid/ready port, captures the returned word into the instruction register
// and reports done, misaligned or bus-timeout as single-cycle pulses.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no request outstanding, waiting for fetch_start
// S_REQ   | request valid on the bus, waiting for ready
// S_WAIT  | request accepted, waiting for the read response
// S_DRAIN | fetch abandoned, swallowing the outstanding response
module instr_fetch_unit #(
  parameter logic [31:0] RESET_INSTR    = 32'h0000_0013,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_start,
  input  logic        i_flush,
  input  logic [31:0] i_pc,
  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ready,
  output logic [31:0] o_mem_req_addr,
  input  logic        i_mem_rsp_valid,
  input  logic [31:0] i_mem_rsp_data,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  output logic        o_instr_valid,
  output logic        o_fetch_done,
  output logic        o_fetch_busy,
  output logic        o_misaligned,
  output logic        o_bus_error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

  state_t      r_state;
  state_t      w_state_next;

  logic [15:0] r_cnt;
  logic [31:0] r_req_addr;
  logic        r_req_valid;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_instr_valid;
  logic        r_fetch_done;
  logic        r_fetch_busy;
  logic        r_misaligned;
  logic        r_bus_error;

  logic [15:0] w_cnt_inc;
  logic        w_expire;
  logic        w_handshake;
  logic        w_start_ok;
  logic        w_start_bad;

  logic [15:0] w_cnt_next;
  logic [31:0] w_req_addr_next;
  logic [31:0] w_instr_next;
  logic [31:0] w_instr_pc_next;
  logic        w_instr_valid_next;
  logic        w_fetch_done_next;
  logic        w_misaligned_next;
  logic        w_bus_error_next;

  // Saturating wait counter; expiry is judged on the incremented value so
  // that exactly TIMEOUT_CYCLES wait cycles elapse before giving up.
  assign w_cnt_inc   = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  assign w_expire    = (w_cnt_inc >= TIMEOUT_VAL);
  assign w_handshake = r_req_valid & i_mem_req_ready;
  assign w_start_ok  = ~i_flush & i_fetch_start & (i_pc[1:0] == 2'b00);
  assign w_start_bad = ~i_flush & i_fetch_start & (i_pc[1:0] != 2'b00);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_next = S_REQ;
      end
      S_REQ: begin
        if (w_handshake)  w_state_next = i_flush ? S_DRAIN : S_WAIT;
        else if (i_flush) w_state_next = S_IDLE;
      end
      S_WAIT: begin
        if (i_flush)              w_state_next = i_mem_rsp_valid ? S_IDLE : S_DRAIN;
        else if (i_mem_rsp_valid) w_state_next = S_IDLE;
        else if (w_expire)        w_state_next = S_IDLE;
      end
      S_DRAIN: begin
        if (i_mem_rsp_valid || w_expire) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath
  always_comb begin
    w_cnt_next         = 16'd0;
    w_req_addr_next    = r_req_addr;
    w_instr_next       = r_instr;
    w_instr_pc_next    = r_instr_pc;
    w_instr_valid_next = r_instr_valid;
    w_fetch_done_next  = 1'b0;
    w_misaligned_next  = 1'b0;
    w_bus_error_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_req_addr_next    = {i_pc[31:2], 2'b00};
          w_instr_valid_next = 1'b0;
        end else if (w_start_bad) begin
          w_misaligned_next  = 1'b1;
          w_instr_valid_next = 1'b0;
        end
      end
      S_WAIT: begin
        w_cnt_next = w_cnt_inc;
        if (!i_flush) begin
          if (i_mem_rsp_valid) begin
            w_instr_next       = i_mem_rsp_data;
            w_instr_pc_next    = r_req_addr;
            w_instr_valid_next = 1'b1;
            w_fetch_done_next  = 1'b1;
          end else if (w_expire) begin
            w_bus_error_next   = 1'b1;
            w_instr_next       = RESET_INSTR;
            w_instr_valid_next = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        w_cnt_next = w_cnt_inc;
      end
      default: begin
        w_cnt_next = 16'd0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt         <= 16'd0;
      r_req_addr    <= 32'd0;
      r_req_valid   <= 1'b0;
      r_instr       <= RESET_INSTR;
      r_instr_pc    <= 32'd0;
      r_instr_valid <= 1'b0;
      r_fetch_done  <= 1'b0;
      r_fetch_busy  <= 1'b0;
      r_misaligned  <= 1'b0;
      r_bus_error   <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_next;
      r_req_addr    <= w_req_addr_next;
      r_req_valid   <= (w_state_next == S_REQ);
      r_instr       <= w_instr_next;
      r_instr_pc    <= w_instr_pc_next;
      r_instr_valid <= w_instr_valid_next;
      r_fetch_done  <= w_fetch_done_next;
      r_fetch_busy  <= (w_state_next != S_IDLE);
      r_misaligned  <= w_misaligned_next;
      r_bus_error   <= w_bus_error_next;
    end
  end

  assign o_mem_req_valid = r_req_valid;
  assign o_mem_req_addr  = r_req_addr;
  assign o_instr         = r_instr;
  assign o_instr_pc      = r_instr_pc;
  assign o_instr_valid   = r_instr_valid;
  assign o_fetch_done    = r_fetch_done;
  assign o_fetch_busy    = r_fetch_busy;
  assign o_misaligned    = r_misaligned;
  assign o_bus_error     = r_bus_error;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a short bus timeout.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_start;
  logic        flush;
  logic [31:0] pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        fetch_done;
  logic        fetch_busy;
  logic        misaligned;
  logic        bus_error;

  int n_checks = 0;
  int n_errors = 0;
  int hs_cnt   = 0;
  int hs_base;

  instr_fetch_unit #(
    .RESET_INSTR   (32'h0000_0013),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_fetch_start  (fetch_start),
    .i_flush        (flush),
    .i_pc           (pc),
    .o_mem_req_valid(mem_req_valid),
    .i_mem_req_ready(mem_req_ready),
    .o_mem_req_addr (mem_req_addr),
    .i_mem_rsp_valid(mem_rsp_valid),
    .i_mem_rsp_data (mem_rsp_data),
    .o_instr        (instr),
    .o_instr_pc     (instr_pc),
    .o_instr_valid  (instr_valid),
    .o_fetch_done   (fetch_done),
    .o_fetch_busy   (fetch_busy),
    .o_misaligned   (misaligned),
    .o_bus_error    (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted requests on the bus
  always @(posedge clk) begin
    if (mem_req_valid && mem_req_ready) hs_cnt <= hs_cnt + 1;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_start = 1'b0; flush = 1'b0; pc = 32'd0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0;
    #1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_instr",     instr, 32'h0000_0013);
    chk("rst_instr_pc",  instr_pc, 32'd0);
    chk("rst_valid",     32'(instr_valid), 32'd0);
    chk("rst_done",      32'(fetch_done), 32'd0);
    chk("rst_misal",     32'(misaligned), 32'd0);
    chk("rst_buserr",    32'(bus_error), 32'd0);
    chk("rst_busy",      32'(fetch_busy), 32'd0);
    chk("rst_reqv",      32'(mem_req_valid), 32'd0);
    chk("rst_addr",      mem_req_addr, 32'd0);
    tick();

    // Minimum-latency fetch at 0x10
    pc = 32'h10; fetch_start = 1'b1; mem_req_ready = 1'b1;
    tick();
    fetch_start = 1'b0;
    chk("f1_reqv_t1",  32'(mem_req_valid), 32'd1);
    chk("f1_addr_t1",  mem_req_addr, 32'h10);
    chk("f1_busy_t1",  32'(fetch_busy), 32'd1);
    tick();
    chk("f1_reqv_t2",  32'(mem_req_valid), 32'd0);
    chk("f1_done_t2",  32'(fetch_done), 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0050_0093;
    tick();
    mem_rsp_valid = 1'b0;
    chk("f1_instr",    instr, 32'h0050_0093);
    chk("f1_instr_pc", instr_pc, 32'h10);
    chk("f1_valid",    32'(instr_valid), 32'd1);
    chk("f1_done_t3",  32'(fetch_done), 32'd1);
    tick();
    chk("f1_done_t4",  32'(fetch_done), 32'd0);
    chk("f1_busy_t4",  32'(fetch_busy), 32'd0);

    // Ready held low for four request cycles
    hs_base = hs_cnt;
    mem_req_ready = 1'b0; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    chk("f2_valid_cleared", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("f2_reqv_%0d", i), 32'(mem_req_valid), 32'd1);
      chk($sformatf("f2_addr_%0d", i), mem_req_addr, 32'h10);
      tick();
    end
    chk("f2_reqv_ready", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    tick();
    chk("f2_reqv_after", 32'(mem_req_valid), 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0050_0093;
    tick();
    mem_rsp_valid = 1'b0;
    chk("f2_instr",    instr, 32'h0050_0093);
    chk("f2_instr_pc", instr_pc, 32'h10);
    chk("f2_done",     32'(fetch_done), 32'd1);
    chk("f2_hs",       32'(hs_cnt - hs_base), 32'd1);
    tick();

    // Misaligned pc
    pc = 32'h6; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    chk("mis_pulse",    32'(misaligned), 32'd1);
    chk("mis_reqv",     32'(mem_req_valid), 32'd0);
    chk("mis_busy",     32'(fetch_busy), 32'd0);
    chk("mis_instr",    instr, 32'h0050_0093);
    chk("mis_instr_pc", instr_pc, 32'h10);
    chk("mis_valid",    32'(instr_valid), 32'd0);
    tick();
    chk("mis_pulse_end", 32'(misaligned), 32'd0);
    chk("mis_reqv2",     32'(mem_req_valid), 32'd0);

    // Flush in WAIT, response two cycles later
    pc = 32'h20; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_busy_d1", 32'(fetch_busy), 32'd1);
    tick();
    chk("fl_busy_d2", 32'(fetch_busy), 32'd1);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
    tick();
    mem_rsp_valid = 1'b0;
    chk("fl_busy_end", 32'(fetch_busy), 32'd0);
    chk("fl_done",     32'(fetch_done), 32'd0);
    chk("fl_instr",    instr, 32'h0050_0093);
    chk("fl_instr_pc", instr_pc, 32'h10);
    tick();

    // Normal fetch after the flush
    pc = 32'h24; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    chk("f3_addr", mem_req_addr, 32'h24);
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0010_0113;
    tick();
    mem_rsp_valid = 1'b0;
    chk("f3_instr",    instr, 32'h0010_0113);
    chk("f3_instr_pc", instr_pc, 32'h24);
    chk("f3_done",     32'(fetch_done), 32'd1);
    tick();

    // Flush in IDLE wins over fetch_start
    pc = 32'h50; fetch_start = 1'b1; flush = 1'b1;
    tick();
    fetch_start = 1'b0; flush = 1'b0;
    chk("fi_reqv", 32'(mem_req_valid), 32'd0);
    chk("fi_busy", 32'(fetch_busy), 32'd0);
    chk("fi_valid", 32'(instr_valid), 32'd1);

    // Flush in REQ without ready: no transaction
    hs_base = hs_cnt;
    mem_req_ready = 1'b0; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fr_reqv", 32'(mem_req_valid), 32'd0);
    chk("fr_busy", 32'(fetch_busy), 32'd0);
    mem_req_ready = 1'b1;
    tick();
    chk("fr_hs", 32'(hs_cnt - hs_base), 32'd0);

    // Flush in REQ together with ready: drain the response
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("frr_busy", 32'(fetch_busy), 32'd1);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1111_2222;
    tick();
    mem_rsp_valid = 1'b0;
    chk("frr_busy_end", 32'(fetch_busy), 32'd0);
    chk("frr_done",     32'(fetch_done), 32'd0);
    chk("frr_instr",    instr, 32'h0010_0113);
    tick();

    // Timeout after 8 WAIT cycles
    pc = 32'h30; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("to_buserr_%0d", i), 32'(bus_error), (i == 8) ? 32'd1 : 32'd0);
    end
    chk("to_instr", instr, 32'h0000_0013);
    chk("to_valid", 32'(instr_valid), 32'd0);
    chk("to_busy",  32'(fetch_busy), 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_F00D;
    tick();
    mem_rsp_valid = 1'b0;
    chk("late_buserr", 32'(bus_error), 32'd0);
    chk("late_instr",  instr, 32'h0000_0013);
    chk("late_done",   32'(fetch_done), 32'd0);
    chk("late_valid",  32'(instr_valid), 32'd0);
    tick();

    // Reset in the middle of WAIT
    pc = 32'h40; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    tick();
    chk("rw_busy_pre", 32'(fetch_busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_busy",  32'(fetch_busy), 32'd0);
    chk("rw_reqv",  32'(mem_req_valid), 32'd0);
    chk("rw_addr",  mem_req_addr, 32'd0);
    chk("rw_instr", instr, 32'h0000_0013);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h3333_4444;
    tick();
    mem_rsp_valid = 1'b0;
    chk("rw_done",  32'(fetch_done), 32'd0);
    chk("rw_valid", 32'(instr_valid), 32'd0);
    chk("rw_instr2", instr, 32'h0000_0013);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of the program counter in the multicycle RV32I core.
- On a fetch request from the control FSM, issues one aligned word read at the current pc over a valid/ready memory port and waits for the response.
- Latches the returned word into the instruction register, together with the pc it came from.
- Pulses fetch_done, which the control FSM uses to raise pc_write.
- Handles flush, misaligned pc and bus timeout. At most one request is outstanding.

Parameters:
- RESET_INSTR, 32'h0000_0013: instruction register value at reset and after an error (addi x0,x0,0 NOP).
- TIMEOUT_CYCLES, 255: maximum number of WAIT cycles before bus_error. Range 1..65535.

Ports:
- clk  input  1  core clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- fetch_start  input  1  request a fetch at pc; sampled only in IDLE.
- flush  input  1  abandon the current fetch (redirect).
- pc  input  32  current program counter.
- mem_req_valid  output  1  read request valid.
- mem_req_ready  input  1  memory accepts the request.
- mem_req_addr  output  32  word address of the request, with bits [1:0]=0.
- mem_rsp_valid  input  1  read data valid.
- mem_rsp_data  input  32  read data.
- instr  output  32  instruction register.
- instr_pc  output  32  pc of the instruction held in instr.
- instr_valid  output  1  instr holds a good fetch result.
- fetch_done  output  1  one-cycle pulse when instr is updated by a good fetch.
- fetch_busy  output  1  high in any state except IDLE.
- misaligned  output  1  one-cycle pulse: fetch_start was sampled with pc[1:0]!=0.
- bus_error  output  1  one-cycle pulse: WAIT timed out.

Behaviour:
- Reset, synchronous, highest priority, usable in any state. On reset:
  - state=IDLE, timeout counter=0;
  - instr=RESET_INSTR, instr_pc=0, instr_valid=0;
  - mem_req_valid=0, mem_req_addr=0;
  - fetch_done, misaligned, bus_error, fetch_busy all 0.
  - An outstanding memory response arriving after reset is ignored.
- All outputs are registered. There is no combinational path from any input to any output.
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE:
  - flush=1 has priority over fetch_start; the unit stays in IDLE.
  - fetch_start=1 with pc[1:0]==0: capture pc into mem_req_addr, set mem_req_valid=1, clear instr_valid, go to REQ.
  - fetch_start=1 with pc[1:0]!=0: pulse misaligned, clear instr_valid, leave instr/instr_pc unchanged, stay in IDLE.
  - mem_rsp_valid is ignored.
- REQ:
  - mem_req_valid=1 and mem_req_addr are held stable until the handshake completes.
  - Handshake (mem_req_valid & mem_req_ready): drop mem_req_valid the next cycle, clear the counter, go to WAIT.
  - flush=1 without ready: drop mem_req_valid, go to IDLE; no transaction is issued.
  - flush=1 in the same cycle as ready: the request is accepted, so go to DRAIN.
  - mem_rsp_valid in REQ is ignored. The response must arrive at the earliest one cycle after the handshake.
- WAIT:
  - mem_rsp_valid=1 and no flush:
    - instr<=mem_rsp_data, instr_pc<=mem_req_addr, instr_valid<=1;
    - pulse fetch_done, go to IDLE.
  - flush=1: go to DRAIN. If mem_rsp_valid=1 in the same cycle, the data is discarded and the unit goes directly to IDLE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES:
    - pulse bus_error, instr<=RESET_INSTR, instr_valid=0, go to IDLE;
    - a response arriving later is ignored while in IDLE.
- DRAIN:
  - Wait for mem_rsp_valid, discard the data, go to IDLE.
  - The same timeout applies, but bus_error stays silent on expiry.
  - flush in DRAIN has no further effect.
- fetch_start outside IDLE is ignored. It is not queued.
- instr and instr_pc keep their last value until the next good fetch or a timeout.
- Latency: fetch_start at cycle t gives mem_req_valid at t+1. With ready at t+1 and response at t+2, instr, instr_valid and fetch_done appear at t+3. Minimum fetch is 3 cycles.
- Counter width is 16 bits and it saturates; it never wraps.

Test Plan:
- Reset then idle: instr=32'h0000_0013, instr_valid=0, all pulses 0, mem_req_valid=0.
- pc=32'h0000_0010, fetch_start pulse, ready=1 immediately, response 32'h0050_0093 one cycle later:
  - mem_req_addr=0x10 at t+1;
  - instr=0x00500093, instr_pc=0x10, fetch_done high exactly one cycle at t+3.
- ready held low for 4 cycles: mem_req_valid and mem_req_addr=0x10 stay stable all 4 cycles; exactly one handshake; result identical to the previous scenario.
- pc=32'h0000_0006, fetch_start: misaligned pulses one cycle, no mem_req_valid, instr unchanged, state stays IDLE.
- flush asserted in WAIT, response 0xDEADBEEF two cycles later: instr unchanged, no fetch_done, fetch_busy high until the response, then IDLE. A new fetch_start afterwards succeeds normally.
- TIMEOUT_CYCLES=8, no response: bus_error pulses after 8 WAIT cycles, instr=RESET_INSTR, instr_valid=0. A late response is ignored. rst asserted mid-WAIT returns the unit to IDLE on the next edge.
